ntt_ram_unloader: RTL and testbench

Read-side sequencer for the dual-lane NTT core coefficient RAM. On a start pulse it walks every (address, lane) location of one core RAM, absorbs the RAM's one-cycle registered read latency, and emits the 60-bit coefficients as a valid/ready stream with full backpressure support. It sits between a core RAM's read port and the result-collection path after the NTT core finishes a transform.

---
 rtl/ntt_ram_unloader.sv | 172 +++++++++++++++++
 tb/tb_ntt_ram_unloader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ram_unloader.sv
// ntt_ram_unloader: walks one dual-lane core RAM and streams its
// coefficients out as a valid/ready stream with a 2-deep skid FIFO.
module ntt_ram_unloader #(
  parameter  int LOG_CORE_COUNT = 5,
  localparam int LOG_N          = 12,
  localparam int AW             = LOG_N - (LOG_CORE_COUNT + 2),
  localparam int HEIGHT         = 1 << AW,
  localparam int WORDS          = 2 * HEIGHT,
  localparam int DW             = 60
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_read_address,
  output logic          ram_read_select,
  input  logic [DW-1:0] ram_data_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;

  logic [AW-1:0]   addr_q, addr_d;
  logic            sel_q, sel_d;

  logic            in_flight_q, in_flight_d;
  logic            fl_last_q, fl_last_d;

  logic            done_q, done_d;

  logic [1:0][DW-1:0] fifo_data_q;
  logic [1:0]      fifo_last_q;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;

  logic            pop;
  logic            push;
  logic            credit;
  logic            issue;
  logic            ptr_last;
  logic            head_last;
  logic            start_ok;
  logic            final_pop;

  // Handshake, credit and issue qualifiers shared by all processes.
  always_comb begin
    pop       = (count_q != 2'd0) && m_ready;
    push      = in_flight_q;
    // Outstanding words after this edge must stay within FIFO depth.
    credit    = ({1'b0, count_q} + {2'b00, in_flight_q})
                < (3'd2 + {2'b00, pop});
    issue     = (state_q == RUN) && credit;
    ptr_last  = {addr_q, sel_q} == (AW + 1)'(WORDS - 1);
    head_last = fifo_last_q[rd_ptr_q];
    // A start landing on the done cycle is dropped.
    start_ok  = start && !done_q;
    final_pop = (state_q == FLUSH) && pop && head_last;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (issue && ptr_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (final_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
  end

  // Read pointer: address-major, lane-minor walk.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if ((state_q == IDLE) && start_ok) begin
      addr_d = '0;
      sel_d  = 1'b0;
    end else if (issue) begin
      sel_d = ~sel_q;
      if (sel_q) addr_d = addr_q + 1'b1;
    end
  end

  // Track the read currently inside the RAM pipeline.
  always_comb begin
    in_flight_d = issue;
    fl_last_d   = issue && ptr_last;
    done_d      = final_pop;
  end

  // Pointer, in-flight and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      sel_q       <= 1'b0;
      in_flight_q <= 1'b0;
      fl_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      in_flight_q <= in_flight_d;
      fl_last_q   <= fl_last_d;
      done_q      <= done_d;
    end
  end

  // Two-entry output FIFO; credit guarantees it never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_data_out;
        fifo_last_q[wr_ptr_q] <= fl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stream and RAM-port outputs.
  always_comb begin
    ram_read_address = addr_q;
    ram_read_select  = sel_q;
    m_valid          = (count_q != 2'd0);
    m_data           = fifo_data_q[rd_ptr_q];
    m_last           = m_valid && head_last;
  end

endmodule

// File: tb/tb_ntt_ram_unloader.sv
// tb_ntt_ram_unloader: scoreboard bench for both AW=5 and AW=6
// instances, each fed by a registered-read RAM model.
module tb_ntt_ram_unloader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic m_ready;
  logic use4;

  always #5 clk = ~clk;

  logic        start0, busy0, done0, sel0, mv0, ml0;
  logic [4:0]  addr0;
  logic [59:0] ram0, md0;

  logic        start4, busy4, done4, sel4, mv4, ml4;
  logic [5:0]  addr4;
  logic [59:0] ram4, md4;

  assign start0 = start & ~use4;
  assign start4 = start & use4;

  ntt_ram_unloader #(.LOG_CORE_COUNT(5)) dut (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0),
    .ram_read_address(addr0), .ram_read_select(sel0),
    .ram_data_out(ram0),
    .m_valid(mv0), .m_ready(m_ready),
    .m_data(md0), .m_last(ml0)
  );

  ntt_ram_unloader #(.LOG_CORE_COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .busy(busy4), .done(done4),
    .ram_read_address(addr4), .ram_read_select(sel4),
    .ram_data_out(ram4),
    .m_valid(mv4), .m_ready(m_ready),
    .m_data(md4), .m_last(ml4)
  );

  // memory[a][s] = 2a+s, one-cycle registered read.
  always @(posedge clk) begin
    ram0 <= 60'({addr0, sel0});
    ram4 <= 60'({addr4, sel4});
  end

  wire        v_o    = use4 ? mv4 : mv0;
  wire [59:0] d_o    = use4 ? md4 : md0;
  wire        l_o    = use4 ? ml4 : ml0;
  wire        busy_o = use4 ? busy4 : busy0;
  wire        done_o = use4 ? done4 : done0;

  int checks   = 0;
  int failures = 0;

  logic [60:0] sb[$];

  typedef struct {
    int id;
    bit use4;
    int ready_pct;
    int init_stall;
    bit poke;
    int exp_words;
    int exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill_sb(input int n);
    sb.delete();
    for (int i = 0; i < n; i++)
      sb.push_back({(i == n - 1), 60'(i)});
  endtask

  task automatic accept_word(inout int words, inout int lasts);
    logic [60:0] e;
    if (sb.size() == 0) begin
      chk("extra_word", 64'(d_o), 64'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("m_data", 64'(d_o), 64'(e[59:0]));
      chk("m_last", 64'(l_o), 64'(e[60]));
    end
    words++;
    if (l_o) lasts++;
  endtask

  task automatic run(input vec_t v);
    int n;
    int words = 0;
    int lasts = 0;
    int dones = 0;
    int bcyc  = 0;
    int tail  = 0;
    bit seen  = 0;
    n = v.use4 ? 128 : 64;
    fill_sb(n);
    use4 = v.use4;
    @(negedge clk);
    start   = 1'b1;
    m_ready = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = (v.poke && c == 30);
      if (c < v.init_stall) m_ready = 1'b0;
      else m_ready = ($urandom_range(99) < v.ready_pct);
      if (v.init_stall > 0 && c == v.init_stall - 1) begin
        chk("stall_valid", 64'(v_o), 64'd1);
        chk("stall_data", 64'(d_o), 64'd0);
        // two reads issued, pointer parked on the next index
        chk("stall_ptr", 64'({addr0, sel0}), 64'd2);
      end
      if (busy_o) bcyc++;
      if (done_o) begin
        dones++;
        chk("done_after_last", 64'(sb.size()), 64'd0);
        seen = 1;
        if (v.poke) start = 1'b1;
      end
      if (v_o && m_ready) accept_word(words, lasts);
      if (seen) tail++;
      if (tail == 5) break;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout vec=%0d actual=no_done required=done", v.id);
    end
    chk("word_count", 64'(words), 64'(v.exp_words));
    chk("last_count", 64'(lasts), 64'd1);
    chk("done_count", 64'(dones), 64'd1);
    chk("idle_after", 64'(busy_o), 64'd0);
    if (v.exp_busy >= 0)
      chk("busy_cycles", 64'(bcyc), 64'(v.exp_busy));
  endtask

  int acc;

  initial begin
    void'($urandom(32'd1234));
    vecs[0] = '{0, 1'b0, 100, 0,  1'b0, 64,  66};
    vecs[1] = '{1, 1'b0, 100, 20, 1'b0, 64,  84};
    vecs[2] = '{2, 1'b0, 50,  0,  1'b0, 64,  -1};
    vecs[3] = '{3, 1'b0, 100, 0,  1'b1, 64,  66};
    vecs[4] = '{4, 1'b1, 100, 0,  1'b0, 128, 130};

    use4    = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_valid", 64'(mv0), 64'd0);
    chk("rst_ptr", 64'({addr0, sel0}), 64'd0);
    chk("rst_data", 64'({ml0, md0}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run(vecs[i]);

    // abort mid-stream after ten accepted words
    use4 = 1'b0;
    fill_sb(64);
    @(negedge clk);
    start   = 1'b1;
    m_ready = 1'b1;
    acc     = 0;
    for (int c = 0; c < 200 && acc < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mv0 && m_ready) begin
        int w, l;
        w = 0;
        l = 0;
        accept_word(w, l);
        acc++;
      end
    end
    chk("pre_abort_words", 64'(acc), 64'd10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_valid", 64'(mv0), 64'd0);
    chk("abort_data", 64'({ml0, md0}), 64'd0);
    chk("abort_ptr", 64'({addr0, sel0}), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("post_abort_done", 64'(done0), 64'd0);
    run(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
